mem_access_ctrl: RTL and testbench

Load/store sequencer for the MEM stage of the pipelined core. It is the initiator side of the data RAM port (`data_ram256x8`: Enable, ReadWrite, Address, DataIn, Size, DataOut). It takes one request at a time from the pipeline over a valid/ready handshake, checks it, and drives the RAM through a setup → enable-pulse → capture sequence. It then returns sign- or zero-extended load data, or a write acknowledge, as a one-cycle response.

---
 rtl/mem_access_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer driving the data RAM port
//
// Purpose: accepts one load/store request at a time over a valid/ready
// handshake, rejects malformed ones, runs SETUP -> STROBE -> CAPTURE against
// the RAM and returns extended load data or a write acknowledge as a
// one-cycle registered response.
//
// Optional feature: define MEMACC_BURST_EN to enable multi-beat word bursts
// (req_count = beats - 1, address advancing by 4 per beat).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_rw, req_size,          request attributes: 1 = write, size 00/01/10,
//   req_signed, req_addr,      sign-extend flag, byte address,
//   req_wdata, req_count       right-justified store data, burst beats - 1
//   rsp_valid, rsp_rdata,      one-cycle response strobe, extended load data,
//   rsp_err, rsp_last          error flag, final-beat flag
//   busy                       state is not IDLE
//   mem_enable, mem_rw,        RAM port outputs (all 0 outside an access)
//   mem_size, mem_addr, mem_din
//   mem_dout                   RAM read data, right-justified

module mem_access_ctrl #(
    parameter int ADDR_LIMIT  = 256,
    parameter int ACCESS_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_count,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        busy,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_rw;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_count;
    logic [3:0]  r_wait;
    logic        r_err;

    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_last;

    logic        w_accept;
    logic        w_active;
    logic [2:0]  w_bytes;
    logic [32:0] w_end;
    logic        w_req_err;
    logic [31:0] w_ext;
    logic [31:0] w_din;

    assign w_accept = req_valid & (r_state == S_IDLE);

    // Request checks run on the raw inputs so an error response can be
    // scheduled at the acceptance edge itself.
    always_comb begin
        w_bytes = 3'd0;
        case (req_size)
            2'b00:   w_bytes = 3'd1;
            2'b01:   w_bytes = 3'd2;
            2'b10:   w_bytes = 3'd4;
            default: w_bytes = 3'd0;
        endcase
`ifdef MEMACC_BURST_EN
        // End of the last beat: addr + 4*count + bytes (count only matters for words).
        w_end = {1'b0, req_addr} + {30'd0, w_bytes}
              + ((req_size == 2'b10) ? {27'd0, req_count, 2'b00} : 33'd0);
`else
        w_end = {1'b0, req_addr} + {30'd0, w_bytes};
`endif
        w_req_err = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                  | (w_end > 33'(ADDR_LIMIT));
`ifdef MEMACC_BURST_EN
        if ((req_size != 2'b10) && (req_count != 4'd0)) begin
            w_req_err = 1'b1;
        end
`endif
    end

`ifndef MEMACC_BURST_EN
    logic w_unused_count;
    assign w_unused_count = ^req_count;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_req_err ? S_RESP : S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_wait == 4'd0) begin
                    w_next = S_STROBE;
                end
            end
            S_STROBE:  w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP: begin
                w_next = ((r_count != 4'd0) && !r_err) ? S_SETUP : S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Load data extension from the RAM's right-justified output.
    always_comb begin
        w_ext = mem_dout;
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & mem_dout[7]}},  mem_dout[7:0]};
            2'b01:   w_ext = {{16{r_signed & mem_dout[15]}}, mem_dout[15:0]};
            default: w_ext = mem_dout;
        endcase
    end

    always_comb begin
        w_din = r_wdata;
        case (r_size)
            2'b00:   w_din = {24'd0, r_wdata[7:0]};
            2'b01:   w_din = {16'd0, r_wdata[15:0]};
            default: w_din = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rw        <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_count     <= 4'd0;
            r_wait      <= 4'd0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_rw     <= req_rw;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
`ifdef MEMACC_BURST_EN
                r_count  <= w_req_err ? 4'd0 : req_count;
`else
                r_count  <= 4'd0;
`endif
            end

            // Next burst beat: advance address and take fresh store data.
            if ((r_state == S_RESP) && (w_next == S_SETUP)) begin
                r_count <= r_count - 4'd1;
                r_addr  <= r_addr + 32'd4;
                r_wdata <= req_wdata;
            end

            if ((r_state != S_SETUP) && (w_next == S_SETUP)) begin
                r_wait <= 4'(ACCESS_WAIT - 1);
            end else if ((r_state == S_SETUP) && (r_wait != 4'd0)) begin
                r_wait <= r_wait - 4'd1;
            end

            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
            if ((r_state == S_IDLE) && (w_next == S_RESP)) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_last  <= 1'b1;
            end else if (r_state == S_CAPTURE) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_rw ? 32'd0 : w_ext;
                r_rsp_last  <= (r_count == 4'd0);
            end
        end
    end

    assign w_active   = (r_state == S_SETUP) | (r_state == S_STROBE) | (r_state == S_CAPTURE);

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign mem_enable = (r_state == S_STROBE);
    assign mem_rw     = w_active ? r_rw   : 1'b0;
    assign mem_size   = w_active ? r_size : 2'b00;
    assign mem_addr   = w_active ? r_addr : 32'd0;
    assign mem_din    = w_active ? w_din  : 32'd0;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign rsp_last   = r_rsp_last;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl

module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_count = 4'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'd0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_LIMIT(256), .ACCESS_WAIT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_count(req_count),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_last(rsp_last), .busy(busy),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Big-endian byte RAM: byte at the lowest address is the most significant.
    logic [7:0] ram [0:255];
    logic [7:0] ram_a;
    always @(posedge clk) begin
        if (mem_enable) begin
            ram_a = mem_addr[7:0];
            if (mem_rw) begin
                case (mem_size)
                    2'b00: ram[ram_a] <= mem_din[7:0];
                    2'b01: begin
                        ram[ram_a]        <= mem_din[15:8];
                        ram[ram_a + 8'd1] <= mem_din[7:0];
                    end
                    default: begin
                        ram[ram_a]        <= mem_din[31:24];
                        ram[ram_a + 8'd1] <= mem_din[23:16];
                        ram[ram_a + 8'd2] <= mem_din[15:8];
                        ram[ram_a + 8'd3] <= mem_din[7:0];
                    end
                endcase
            end else begin
                case (mem_size)
                    2'b00:   mem_dout <= {24'd0, ram[ram_a]};
                    2'b01:   mem_dout <= {16'd0, ram[ram_a], ram[ram_a + 8'd1]};
                    default: mem_dout <= {ram[ram_a], ram[ram_a + 8'd1],
                                          ram[ram_a + 8'd2], ram[ram_a + 8'd3]};
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          g_lat;
    int          g_en;
    logic        g_found;
    logic [31:0] g_rdata;
    logic        g_err;
    logic        g_last;
    logic [31:0] g_din;
    logic [1:0]  g_msize;
    logic        g_ready1;
    logic        g_busy1;

    // Issues one request and watches negedges after the acceptance edge:
    // k=1 is the cycle right after acceptance.
    task automatic run_req(input logic rw, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] cnt);
        @(negedge clk);
        req_rw = rw; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd; req_count = cnt;
        req_valid = 1'b1;
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        g_found = 1'b0; g_lat = 0; g_en = 0;
        g_rdata = 32'hDEAD_BEEF; g_err = 1'bx; g_last = 1'bx;
        g_din = 32'd0; g_msize = 2'b11; g_ready1 = 1'bx; g_busy1 = 1'bx;
        for (int k = 1; k <= 40 && !g_found; k++) begin
            @(negedge clk);
            if (k == 1) begin
                g_ready1 = req_ready;
                g_busy1  = busy;
            end
            if (mem_enable) begin
                g_en++;
                g_din   = mem_din;
                g_msize = mem_size;
            end
            if (rsp_valid) begin
                g_found = 1'b1;
                g_lat   = k;
                g_rdata = rsp_rdata;
                g_err   = rsp_err;
                g_last  = rsp_last;
            end
        end
        if (!g_found) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_ok(input string tag, input logic [31:0] exp_rdata);
        chk({tag, "_rdata"}, g_rdata, exp_rdata);
        chk({tag, "_err"}, {31'd0, g_err}, 32'd0);
        chk({tag, "_lat"}, g_lat, 32'd4);
        chk({tag, "_en"}, g_en, 32'd1);
        chk({tag, "_last"}, {31'd0, g_last}, 32'd1);
        chk({tag, "_ready1"}, {31'd0, g_ready1}, 32'd0);
        chk({tag, "_busy1"}, {31'd0, g_busy1}, 32'd1);
    endtask

    task automatic chk_bad(input string tag);
        chk({tag, "_err"}, {31'd0, g_err}, 32'd1);
        chk({tag, "_lat"}, g_lat, 32'd1);
        chk({tag, "_en"}, g_en, 32'd0);
        chk({tag, "_rdata"}, g_rdata, 32'd0);
        chk({tag, "_last"}, {31'd0, g_last}, 32'd1);
    endtask

    int   n_rsp;
    int   n_en;
    logic [31:0] b_addr [0:7];
    logic [31:0] b_data [0:7];
    logic        b_last [0:7];
    int          b_lat  [0:7];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0] = 8'h85; ram[1] = 8'hC3; ram[2] = 8'hA2; ram[3] = 8'h1F;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Preloaded word
        run_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 4'd0);
        chk_ok("rd_w0", 32'h85C3A21F);

        // Byte write masks upper store bits
        run_req(1'b1, 2'b00, 1'b0, 32'd0, 32'h123456B5, 4'd0);
        chk_ok("wr_b0", 32'd0);
        chk("wr_b0_din", g_din, 32'h000000B5);
        chk("wr_b0_size", {30'd0, g_msize}, 32'd0);

        run_req(1'b0, 2'b00, 1'b1, 32'd0, 32'd0, 4'd0);
        chk_ok("rd_b0_s", 32'hFFFFFFB5);
        run_req(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 4'd0);
        chk_ok("rd_b0_u", 32'h000000B5);

        // Half write, then signed/unsigned half reads
        run_req(1'b1, 2'b01, 1'b0, 32'd2, 32'hABCDFFD3, 4'd0);
        chk_ok("wr_h2", 32'd0);
        chk("wr_h2_din", g_din, 32'h0000FFD3);
        chk("wr_h2_size", {30'd0, g_msize}, 32'd1);
        @(negedge clk);
        chk("idle_mem_din", mem_din, 32'd0);
        chk("idle_mem_size", {30'd0, mem_size}, 32'd0);

        run_req(1'b0, 2'b01, 1'b1, 32'd2, 32'd0, 4'd0);
        chk_ok("rd_h2_s", 32'hFFFFFFD3);
        run_req(1'b0, 2'b01, 1'b0, 32'd2, 32'd0, 4'd0);
        chk_ok("rd_h2_u", 32'h0000FFD3);

        // Word write/read back
        run_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hE35D8AC5, 4'd0);
        chk_ok("wr_w8", 32'd0);
        chk("wr_w8_din", g_din, 32'hE35D8AC5);
        run_req(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 4'd0);
        chk_ok("rd_w8", 32'hE35D8AC5);

        // Boundary accesses that just fit
        run_req(1'b0, 2'b10, 1'b0, 32'd252, 32'd0, 4'd0);
        chk_ok("rd_w252", 32'd0);
        run_req(1'b0, 2'b00, 1'b0, 32'd255, 32'd0, 4'd0);
        chk_ok("rd_b255", 32'd0);

        // Error requests
        run_req(1'b0, 2'b10, 1'b0, 32'd6, 32'd0, 4'd0);
        chk_bad("err_w6");
        run_req(1'b0, 2'b01, 1'b0, 32'd3, 32'd0, 4'd0);
        chk_bad("err_h3");
        run_req(1'b0, 2'b10, 1'b0, 32'd254, 32'd0, 4'd0);
        chk_bad("err_w254");
        run_req(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 4'd0);
        chk_bad("err_sz3");
        run_req(1'b1, 2'b00, 1'b0, 32'd256, 32'd0, 4'd0);
        chk_bad("err_b256");
        chk("err_b256_ready1", {31'd0, g_ready1}, 32'd0);

`ifdef MEMACC_BURST_EN
        // Four-beat word read burst at 0
        @(negedge clk);
        req_rw = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_count = 4'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_rsp = 0; n_en = 0;
        for (int k = 1; k <= 80 && n_rsp < 8; k++) begin
            @(negedge clk);
            if (mem_enable && n_en < 8) begin
                b_addr[n_en] = mem_addr;
                n_en++;
            end
            if (rsp_valid) begin
                b_data[n_rsp] = rsp_rdata;
                b_last[n_rsp] = rsp_last;
                b_lat[n_rsp]  = k;
                n_rsp++;
                if (rsp_last) break;
            end
        end
        chk("bst_n_rsp", n_rsp, 32'd4);
        chk("bst_n_en", n_en, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bst_addr%0d", i), b_addr[i], 32'(4 * i));
            chk($sformatf("bst_last%0d", i), {31'd0, b_last[i]}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("bst_lat%0d", i), b_lat[i], 32'(4 * (i + 1)));
        end
        chk("bst_data0", b_data[0], 32'hB5C3FFD3);
        chk("bst_data1", b_data[1], 32'h00000000);
        chk("bst_data2", b_data[2], 32'hE35D8AC5);
        chk("bst_data3", b_data[3], 32'h00000000);
        run_req(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 4'd1);
        chk_bad("bst_err_byte");
`else
        // Burst count is ignored: single beat, last set
        run_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 4'd3);
        chk_ok("cnt_ignored", 32'hB5C3FFD3);
`endif

        // Reset during STROBE of a write
        @(negedge clk);
        req_rw = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'd16; req_wdata = 32'h11223344; req_count = 4'd0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_strobe_en", {31'd0, mem_enable}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", {31'd0, mem_enable}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        n_rsp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        chk("mid_rst_no_rsp", n_rsp, 32'd0);

        // Normal operation after mid-flight reset
        run_req(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 4'd0);
        chk_ok("post_rst_rd_w8", 32'hE35D8AC5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
